// File: rtl/parking_spot_allocator.sv
// Parking occupancy sequencer: round-robin entry arbitration, lowest-free-spot
// allocation, and exit handling on a shared occupancy register.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for any entry_req; latches the round-robin winner
//   S_GRANT | allocates a spot (or rejects if full), pulses ack/reject
//   S_DROP  | requester sees the pulse and drops its request
module parking_spot_allocator #(
    parameter int N_SPOTS = 8,
    parameter int N_GATES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_GATES-1:0]             entry_req,
    output logic [N_GATES-1:0]             entry_ack,
    output logic [N_GATES-1:0]             entry_reject,
    output logic [N_SPOTS-1:0]             entry_spot,
    input  logic                           exit_valid,
    input  logic [N_SPOTS-1:0]             exit_spot,
    output logic                           exit_err,
    output logic [N_SPOTS-1:0]             occupancy,
    output logic [$clog2(N_SPOTS+1)-1:0]   free_count,
    output logic                           full
);
    localparam int GW = (N_GATES > 1) ? $clog2(N_GATES) : 1;
    localparam int CW = $clog2(N_SPOTS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t             state;
    logic [GW-1:0]      rr;
    logic [GW-1:0]      sel;
    logic [GW-1:0]      sel_next;
    logic [GW-1:0]      idx;
    logic [GW-1:0]      rr_inc;
    logic               found;
    logic               exit_onehot;
    logic               exit_ok;
    logic [N_SPOTS-1:0] exit_mask;
    logic [N_SPOTS-1:0] alloc_mask;
    logic [CW-1:0]      ones;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_next = rr;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_GATES; i++) begin
            idx = GW'((int'(rr) + i) % N_GATES);
            if (!found && entry_req[idx]) begin
                found    = 1'b1;
                sel_next = idx;
            end
        end
    end

    assign rr_inc = (sel == GW'(N_GATES - 1)) ? '0 : sel + GW'(1);

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            ones = ones + CW'(occupancy[i]);
        end
        free_count = CW'(N_SPOTS) - ones;
    end

    assign full = &occupancy;

    assign exit_onehot = (exit_spot != '0) &&
                         ((exit_spot & (exit_spot - N_SPOTS'(1))) == '0);
    assign exit_ok     = exit_valid && exit_onehot && ((occupancy & exit_spot) != '0);
    assign exit_mask   = exit_ok ? exit_spot : '0;

    // Lowest clear bit isolated; uses pre-edge occupancy so a spot freed
    // on the same edge is never handed out again in that cycle.
    assign alloc_mask  = (state == S_GRANT && !full) ?
                         (~occupancy & (occupancy + N_SPOTS'(1))) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rr           <= '0;
            sel          <= '0;
            occupancy    <= '0;
            entry_ack    <= '0;
            entry_reject <= '0;
            entry_spot   <= '0;
            exit_err     <= 1'b0;
        end else begin
            entry_ack    <= '0;
            entry_reject <= '0;
            entry_spot   <= '0;
            exit_err     <= exit_valid && !exit_ok;
            occupancy    <= (occupancy & ~exit_mask) | alloc_mask;
            case (state)
                S_IDLE: begin
                    if (|entry_req) begin
                        sel   <= sel_next;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!full) begin
                        entry_ack[sel] <= 1'b1;
                        entry_spot     <= alloc_mask;
                    end else begin
                        entry_reject[sel] <= 1'b1;
                    end
                    rr    <= rr_inc;
                    state <= S_DROP;
                end
                S_DROP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_spot_allocator.sv
// Directed self-checking bench for parking_spot_allocator (8 spots, 2 gates).
module tb_parking_spot_allocator;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] entry_req;
    logic [1:0] entry_ack;
    logic [1:0] entry_reject;
    logic [7:0] entry_spot;
    logic       exit_valid;
    logic [7:0] exit_spot;
    logic       exit_err;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;

    int checks = 0;
    int errors = 0;

    parking_spot_allocator #(.N_SPOTS(8), .N_GATES(2)) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .entry_ack(entry_ack),
        .entry_reject(entry_reject), .entry_spot(entry_spot),
        .exit_valid(exit_valid), .exit_spot(exit_spot), .exit_err(exit_err),
        .occupancy(occupancy), .free_count(free_count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises the request, waits (bounded) for ack/reject, drops it, and
    // returns after the FSM is back in IDLE.
    task automatic do_req(input logic [1:0] gates, output logic [1:0] ack,
                          output logic [1:0] rej, output logic [7:0] spot,
                          output int lat);
        entry_req = gates;
        ack = '0; rej = '0; spot = '0; lat = 99;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if ((entry_ack | entry_reject) != 2'b00) begin
                ack = entry_ack; rej = entry_reject; spot = entry_spot; lat = i;
                break;
            end
        end
        entry_req = 2'b00;
        tick();
    endtask

    task automatic do_exit(input logic [7:0] spot);
        exit_valid = 1'b1;
        exit_spot  = spot;
        tick();
        exit_valid = 1'b0;
        exit_spot  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (occupancy !== 8'h00 || free_count !== 4'd8 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_occ: occ=%h free=%0d full=%b expected occ=00 free=8 full=0", occupancy, free_count, full);
        end
        checks++;
        if (entry_ack !== 2'b00 || entry_reject !== 2'b00 || entry_spot !== 8'h00 || exit_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: ack=%b rej=%b spot=%h err=%b expected all zero", entry_ack, entry_reject, entry_spot, exit_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_grant();
        logic [1:0] ack, rej; logic [7:0] spot; int lat;
        do_req(2'b01, ack, rej, spot, lat);
        checks++;
        if (ack !== 2'b01 || lat != 2) begin
            errors++;
            $display("FAIL single_ack: ack=%b lat=%0d expected ack=01 lat=2", ack, lat);
        end
        checks++;
        if (spot !== 8'b00000001) begin
            errors++;
            $display("FAIL single_spot: got %b expected 00000001", spot);
        end
        checks++;
        if (occupancy !== 8'h01 || free_count !== 4'd7) begin
            errors++;
            $display("FAIL single_occ: occ=%h free=%0d expected occ=01 free=7", occupancy, free_count);
        end
        checks++;
        if (entry_ack !== 2'b00 || entry_spot !== 8'h00) begin
            errors++;
            $display("FAIL single_pulse_len: ack=%b spot=%h expected 00/00", entry_ack, entry_spot);
        end
    endtask

    task automatic test_round_robin();
        int gap;
        apply_reset();
        entry_req = 2'b11;
        tick(); tick();
        checks++;
        if (entry_ack !== 2'b01 || entry_spot !== 8'h01) begin
            errors++;
            $display("FAIL rr_first: ack=%b spot=%h expected 01/01", entry_ack, entry_spot);
        end
        // Gate0 drops, then re-requests; rr now favours gate1.
        entry_req = 2'b10;
        tick();
        entry_req = 2'b11;
        gap = 99;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (entry_ack != 2'b00) begin gap = i; break; end
        end
        checks++;
        if (entry_ack !== 2'b10 || entry_spot !== 8'h02 || gap != 3) begin
            errors++;
            $display("FAIL rr_second: ack=%b spot=%h gap=%0d expected 10/02 gap=3", entry_ack, entry_spot, gap);
        end
        entry_req = 2'b01;
        tick(); tick(); tick();
        checks++;
        if (entry_ack !== 2'b01 || entry_spot !== 8'h04 || occupancy !== 8'h07) begin
            errors++;
            $display("FAIL rr_third: ack=%b spot=%h occ=%h expected 01/04/07", entry_ack, entry_spot, occupancy);
        end
        entry_req = 2'b00;
        tick();
    endtask

    task automatic test_fill_full();
        logic [1:0] ack, rej; logic [7:0] spot; int lat;
        apply_reset();
        for (int i = 0; i < 8; i++) do_req(2'b01, ack, rej, spot, lat);
        do_exit(8'h10);
        checks++;
        if (occupancy !== 8'b11101111 || exit_err !== 1'b0 || free_count !== 4'd1) begin
            errors++;
            $display("FAIL fill_preload: occ=%b err=%b free=%0d expected 11101111/0/1", occupancy, exit_err, free_count);
        end
        do_req(2'b01, ack, rej, spot, lat);
        checks++;
        if (ack !== 2'b01 || spot !== 8'b00010000) begin
            errors++;
            $display("FAIL fill_last: ack=%b spot=%b expected 01/00010000", ack, spot);
        end
        checks++;
        if (occupancy !== 8'hFF || full !== 1'b1 || free_count !== 4'd0) begin
            errors++;
            $display("FAIL fill_full: occ=%h full=%b free=%0d expected FF/1/0", occupancy, full, free_count);
        end
        do_req(2'b01, ack, rej, spot, lat);
        checks++;
        if (rej !== 2'b01 || ack !== 2'b00 || spot !== 8'h00 || lat != 2 || occupancy !== 8'hFF) begin
            errors++;
            $display("FAIL full_reject: rej=%b ack=%b spot=%h lat=%0d occ=%h expected 01/00/00/2/FF", rej, ack, spot, lat, occupancy);
        end
    endtask

    task automatic test_exit_during_grant();
        logic [1:0] ack, rej; logic [7:0] spot; int lat;
        entry_req = 2'b01;
        tick();
        exit_valid = 1'b1; exit_spot = 8'b00000100;
        tick();
        exit_valid = 1'b0; exit_spot = '0; entry_req = 2'b00;
        checks++;
        if (entry_reject !== 2'b01 || entry_ack !== 2'b00 || occupancy !== 8'b11111011 || exit_err !== 1'b0) begin
            errors++;
            $display("FAIL full_exit_same_edge: rej=%b ack=%b occ=%b err=%b expected 01/00/11111011/0", entry_reject, entry_ack, occupancy, exit_err);
        end
        tick();
        // Allocation of spot 2 while spot 0 leaves on the same edge.
        entry_req = 2'b01;
        tick();
        exit_valid = 1'b1; exit_spot = 8'b00000001;
        tick();
        exit_valid = 1'b0; exit_spot = '0; entry_req = 2'b00;
        checks++;
        if (entry_ack !== 2'b01 || entry_spot !== 8'b00000100 || occupancy !== 8'b11111110) begin
            errors++;
            $display("FAIL alloc_exit_same_edge: ack=%b spot=%b occ=%b expected 01/00000100/11111110", entry_ack, entry_spot, occupancy);
        end
        tick();
        do_req(2'b01, ack, rej, spot, lat);
        checks++;
        if (ack !== 2'b01 || spot !== 8'h01 || occupancy !== 8'hFF) begin
            errors++;
            $display("FAIL reuse_freed: ack=%b spot=%h occ=%h expected 01/01/FF", ack, spot, occupancy);
        end
    endtask

    task automatic test_exit_err();
        do_exit(8'b00000011);
        checks++;
        if (exit_err !== 1'b1 || occupancy !== 8'hFF) begin
            errors++;
            $display("FAIL exit_multihot: err=%b occ=%h expected 1/FF", exit_err, occupancy);
        end
        tick();
        checks++;
        if (exit_err !== 1'b0) begin
            errors++;
            $display("FAIL exit_err_len: err=%b expected 0", exit_err);
        end
        do_exit(8'h00);
        checks++;
        if (exit_err !== 1'b1 || occupancy !== 8'hFF) begin
            errors++;
            $display("FAIL exit_zero: err=%b occ=%h expected 1/FF", exit_err, occupancy);
        end
        do_exit(8'h80);
        checks++;
        if (exit_err !== 1'b0 || occupancy !== 8'h7F) begin
            errors++;
            $display("FAIL exit_legal: err=%b occ=%h expected 0/7F", exit_err, occupancy);
        end
        do_exit(8'h80);
        checks++;
        if (exit_err !== 1'b1 || occupancy !== 8'h7F) begin
            errors++;
            $display("FAIL exit_free_spot: err=%b occ=%h expected 1/7F", exit_err, occupancy);
        end
        tick();
    endtask

    task automatic test_reset_in_grant();
        logic [1:0] ack, rej; logic [7:0] spot; int lat;
        entry_req = 2'b01;
        tick();
        reset = 1'b1; entry_req = 2'b00;
        tick();
        checks++;
        if (entry_ack !== 2'b00 || entry_reject !== 2'b00 || entry_spot !== 8'h00 ||
            occupancy !== 8'h00 || free_count !== 4'd8 || full !== 1'b0 || exit_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_grant: ack=%b rej=%b spot=%h occ=%h free=%0d full=%b err=%b expected all reset values",
                     entry_ack, entry_reject, entry_spot, occupancy, free_count, full, exit_err);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (entry_ack !== 2'b00 || occupancy !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_late_ack: ack=%b occ=%h expected 00/00", entry_ack, occupancy);
        end
        do_req(2'b11, ack, rej, spot, lat);
        checks++;
        if (ack !== 2'b01 || spot !== 8'h01 || lat != 2) begin
            errors++;
            $display("FAIL post_reset_grant: ack=%b spot=%h lat=%0d expected 01/01/2", ack, spot, lat);
        end
    endtask

    initial begin
        reset = 1'b1; entry_req = 2'b00; exit_valid = 1'b0; exit_spot = 8'h00;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_fill_full();
        test_exit_during_grant();
        test_exit_err();
        test_reset_in_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
